// File: rtl/rst_req_gen.sv
// rst_req_gen: turns button, software and PLL-loss causes into a stretched, rate-limited reset request
module rst_req_gen #(
    parameter int DEBOUNCE_CYCLES = 200000,
    parameter int PULSE_CYCLES    = 64,
    parameter int HOLDOFF_CYCLES  = 1024,
    parameter int CNT_WIDTH       = 20
) (
    input  logic       clk_in,
    input  logic       rst_in,
    input  logic       btn_n_in,
    input  logic       sw_req_in,
    input  logic       pll_locked_in,
    output logic       rst_req_out,
    output logic       busy_out,
    output logic [2:0] cause_out,
    output logic [7:0] req_cnt_out
);
    typedef enum logic [1:0] {IDLE, ASSERT, HOLDOFF} state_t;
    state_t state, state_nx;
    logic btn_s1, btn_s2, btn_deb, lk_s1, lk_s2, lk_s3, lock_armed;
    logic btn_evt, lock_evt, deb_done, pulse_end, hold_end;
    logic [CNT_WIDTH-1:0] deb_cnt, timer, timer_nx;
    logic [2:0] evt, pending, pending_nx, cause_nx;
    logic [7:0] cnt_nx, cnt_inc;

    assign deb_done  = (btn_s2 != btn_deb) && (deb_cnt == CNT_WIDTH'(DEBOUNCE_CYCLES - 1));
    assign btn_evt   = deb_done & ~btn_s2;
    assign lock_evt  = lk_s3 & ~lk_s2 & lock_armed;
    assign evt       = {lock_evt, sw_req_in, btn_evt};
    assign pulse_end = timer == CNT_WIDTH'(PULSE_CYCLES - 1);
    assign hold_end  = timer == CNT_WIDTH'(HOLDOFF_CYCLES - 1);
    assign cnt_inc   = req_cnt_out + {7'd0, req_cnt_out != 8'hff};
    assign busy_out  = state != IDLE;

    // two-flop synchronisers; lock_armed remembers that lock was ever seen
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            btn_s1     <= 1'b1;
            btn_s2     <= 1'b1;
            lk_s1      <= 1'b0;
            lk_s2      <= 1'b0;
            lk_s3      <= 1'b0;
            lock_armed <= 1'b0;
        end else begin
            btn_s1     <= btn_n_in;
            btn_s2     <= btn_s1;
            lk_s1      <= pll_locked_in;
            lk_s2      <= lk_s1;
            lk_s3      <= lk_s2;
            lock_armed <= lock_armed | lk_s2;
        end
    end

    // debounce: accept a new button level after enough consecutive mismatching cycles
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            btn_deb <= 1'b1;
            deb_cnt <= '0;
        end else begin
            btn_deb <= deb_done ? btn_s2 : btn_deb;
            deb_cnt <= (btn_s2 == btn_deb || deb_done) ? '0 : deb_cnt + 1'b1;
        end
    end

    // request FSM next state: pulse, then holdoff collecting causes that arrive meanwhile
    always_comb begin
        state_nx   = state;
        timer_nx   = '0;
        cause_nx   = cause_out;
        pending_nx = pending;
        cnt_nx     = req_cnt_out;
        case (state)
            IDLE: begin
                if (|evt) begin
                    state_nx = ASSERT;
                    cause_nx = evt;
                    cnt_nx   = cnt_inc;
                end
            end
            ASSERT: begin
                cause_nx = cause_out | evt;
                state_nx = pulse_end ? HOLDOFF : ASSERT;
                timer_nx = pulse_end ? '0 : timer + 1'b1;
            end
            HOLDOFF: begin
                if (hold_end) begin
                    pending_nx = '0;
                    if (|(pending | evt)) begin
                        state_nx = ASSERT;
                        cause_nx = pending | evt;
                        cnt_nx   = cnt_inc;
                    end else begin
                        state_nx = IDLE;
                    end
                end else begin
                    timer_nx   = timer + 1'b1;
                    pending_nx = pending | evt;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    // FSM and status registers; the request output is registered from the next state
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            state       <= IDLE;
            timer       <= '0;
            cause_out   <= '0;
            pending     <= '0;
            req_cnt_out <= '0;
            rst_req_out <= 1'b0;
        end else begin
            state       <= state_nx;
            timer       <= timer_nx;
            cause_out   <= cause_nx;
            pending     <= pending_nx;
            req_cnt_out <= cnt_nx;
            rst_req_out <= state_nx == ASSERT;
        end
    end
endmodule

// File: tb/tb_rst_req_gen.sv
// tb_rst_req_gen: scoreboard bench for rst_req_gen with a small debounce/pulse/holdoff configuration
module tb_rst_req_gen;
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       btn_n = 1'b1;
    logic       sw = 1'b0;
    logic       lock = 1'b0;
    logic       rst_req;
    logic       busy;
    logic [2:0] cause;
    logic [7:0] req_cnt;

    typedef struct {
        int         st;
        int         ln;
        logic [2:0] cs;
        int         cn;
    } exp_t;

    exp_t q[$];
    int   cyc = 0;
    int   n_chk = 0;
    int   n_pass = 0;
    int   ec = 0;

    rst_req_gen #(
        .DEBOUNCE_CYCLES(4),
        .PULSE_CYCLES   (8),
        .HOLDOFF_CYCLES (16),
        .CNT_WIDTH      (20)
    ) dut (
        .clk_in       (clk),
        .rst_in       (rst),
        .btn_n_in     (btn_n),
        .sw_req_in    (sw),
        .pll_locked_in(lock),
        .rst_req_out  (rst_req),
        .busy_out     (busy),
        .cause_out    (cause),
        .req_cnt_out  (req_cnt)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= rst ? 0 : cyc + 1;

    task automatic check(string nm, logic [31:0] act, logic [31:0] exp);
        n_chk++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
    endtask

    task automatic go(int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic expect_pulse(int st, int ln, logic [2:0] cs);
        exp_t e;
        ec = (ec == 255) ? 255 : ec + 1;
        e.st = st;
        e.ln = ln;
        e.cs = cs;
        e.cn = ec;
        q.push_back(e);
    endtask

    task automatic sw_pulse();
        sw = 1'b1;
        go(1);
        sw = 1'b0;
    endtask

    // monitor: measures each rst_req pulse and compares it with the oldest expected pulse
    initial begin
        logic prev;
        int   st, ln, cn;
        exp_t e;
        prev = 1'b0;
        st = 0;
        ln = 0;
        cn = 0;
        forever begin
            @(posedge clk);
            #1;
            if (rst_req && !prev) begin
                st = cyc;
                ln = 1;
                cn = int'(req_cnt);
            end else if (rst_req) begin
                ln++;
            end else if (prev) begin
                if (q.size() == 0) begin
                    check("unexpected_pulse_start", st, 32'hffffffff);
                end else begin
                    e = q.pop_front();
                    check("pulse_start", st, e.st);
                    check("pulse_len", ln, e.ln);
                    check("pulse_cause", cause, e.cs);
                    check("pulse_cnt", cn, e.cn);
                end
            end
            prev = rst_req;
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int t;
        go(3);
        check("reset_rst_req", rst_req, 0);
        check("reset_busy", busy, 0);
        check("reset_cause", cause, 0);
        check("reset_cnt", req_cnt, 0);
        rst = 1'b0;
        go(10);
        sw_pulse();
        expect_pulse(11, 8, 3'b010);
        go(23);
        check("busy_cycle34", busy, 1);
        check("cause_sw", cause, 3'b010);
        check("cnt_first", req_cnt, 1);
        go(1);
        check("busy_cycle35", busy, 0);
        go(5);
        for (int i = 0; i < 5; i++) begin
            btn_n = 1'b0;
            go(2);
            btn_n = 1'b1;
            go(2);
        end
        btn_n = 1'b0;
        expect_pulse(cyc + 6, 8, 3'b001);
        go(60);
        btn_n = 1'b1;
        go(20);
        go(50);
        check("no_lock_cnt", req_cnt, 2);
        check("no_lock_busy", busy, 0);
        lock = 1'b1;
        go(10);
        lock = 1'b0;
        expect_pulse(cyc + 3, 8, 3'b100);
        go(40);
        t = cyc;
        expect_pulse(t + 1, 8, 3'b010);
        sw_pulse();
        go(1);
        sw_pulse();
        go(9);
        expect_pulse(t + 25, 8, 3'b010);
        sw_pulse();
        go(45);
        t = cyc;
        expect_pulse(t + 1, 8, 3'b010);
        sw_pulse();
        go(23);
        expect_pulse(t + 25, 8, 3'b010);
        sw_pulse();
        go(50);
        check("cnt_before_rst", req_cnt, 7);
        expect_pulse(cyc + 1, 4, 3'b000);
        sw_pulse();
        go(3);
        rst = 1'b1;
        #1;
        check("midrst_rst_req", rst_req, 0);
        check("midrst_busy", busy, 0);
        check("midrst_cause", cause, 0);
        check("midrst_cnt", req_cnt, 0);
        go(3);
        rst = 1'b0;
        ec = 0;
        go(40);
        check("post_rst_rst_req", rst_req, 0);
        check("post_rst_cnt", req_cnt, 0);
        check("post_rst_busy", busy, 0);
        for (int i = 0; i < 300; i++) begin
            expect_pulse(cyc + 1, 8, 3'b010);
            sw_pulse();
            go(29);
        end
        go(30);
        check("cnt_saturated", req_cnt, 255);
        check("queue_empty", q.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
